// File: rtl/alu_scalar_pkg.sv
// Shared types and constants for the scalar ALU pipeline: branch condition codes,
// NZVC flag bit positions and the EX/MEM occupancy states.
package alu_scalar_pkg;

   typedef enum logic [2:0] {
      AL = 3'b000,
      EQ = 3'b001,
      NE = 3'b010,
      LT = 3'b011,
      GE = 3'b100,
      GT = 3'b101,
      LE = 3'b110,
      CS = 3'b111
   } cond_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_scalar_ex_mem_stage_cond_eval.sv
// Combinational branch-condition evaluator over an NZVC flag vector.
// Kept free of pipeline state so the vector path can reuse it.
module cond_eval
   import alu_scalar_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [2:0] cond,
   output logic       cond_true
);

   logic flag_n;
   logic flag_z;
   logic flag_v;
   logic flag_c;
   logic signed_lt;

   assign flag_n    = flags[FLAG_N];
   assign flag_z    = flags[FLAG_Z];
   assign flag_v    = flags[FLAG_V];
   assign flag_c    = flags[FLAG_C];
   assign signed_lt = flag_n ^ flag_v;

   always_comb begin
      cond_true = 1'b0;
      case (cond_t'(cond))
         AL:      cond_true = 1'b1;
         EQ:      cond_true = flag_z;
         NE:      cond_true = !flag_z;
         LT:      cond_true = signed_lt;
         GE:      cond_true = !signed_lt;
         GT:      cond_true = !flag_z && !signed_lt;
         LE:      cond_true = flag_z || signed_lt;
         CS:      cond_true = flag_c;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_scalar_ex_mem_stage.sv
// EX/MEM pipeline register for the scalar ALU: holds the result packet, owns the
// NZVC flag register and resolves branches. ALU_SCALAR_EXMEM_PERF_EN adds perf counters.
module alu_scalar_ex_mem_stage
   import alu_scalar_pkg::*;
#(
   parameter int N  = 32,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  alu_c,
   input  logic [3:0]    alu_flags,
   input  logic          set_flags,
   input  logic [RW-1:0] rd,
   input  logic          wr_en,
   input  logic          is_branch,
   input  logic [2:0]    cond,
   input  logic          flush,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [N-1:0]  out_result,
   output logic [RW-1:0] out_rd,
   output logic          out_wr_en,
   output logic          out_taken,
   output logic [3:0]    flags_q
`ifdef ALU_SCALAR_EXMEM_PERF_EN
   ,
   output logic [31:0]   perf_retired,
   output logic [31:0]   perf_stall
`endif
);

   state_t        state_reg;
   state_t        state_next;
   logic [N-1:0]  result_reg;
   logic [RW-1:0] rd_reg;
   logic          wr_en_reg;
   logic          taken_reg;
   logic [3:0]    flags_reg;
   logic          cond_true;
   logic          accept;

   assign out_valid = (state_reg == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready && !flush;

   // Evaluated against the pre-update flags, so a flag-setting branch sees prior flags.
   cond_eval u_cond_eval (
      .flags     (flags_reg),
      .cond      (cond),
      .cond_true (cond_true)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: begin
            if (accept) state_next = FULL;
         end
         FULL: begin
            if (flush)                      state_next = EMPTY;
            else if (out_ready && !accept)  state_next = EMPTY;
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= EMPTY;
         result_reg <= '0;
         rd_reg     <= '0;
         wr_en_reg  <= 1'b0;
         taken_reg  <= 1'b0;
         flags_reg  <= 4'b0000;
      end else begin
         state_reg <= state_next;
         if (flush) begin
            wr_en_reg <= 1'b0;
         end else if (accept) begin
            result_reg <= alu_c;
            rd_reg     <= rd;
            wr_en_reg  <= wr_en;
            taken_reg  <= is_branch && cond_true;
            if (set_flags) flags_reg <= alu_flags;
         end
      end
   end

   assign out_result = result_reg;
   assign out_rd     = rd_reg;
   assign out_wr_en  = wr_en_reg && out_valid;
   assign out_taken  = taken_reg;
   assign flags_q    = flags_reg;

`ifdef ALU_SCALAR_EXMEM_PERF_EN
   logic [31:0] retired_reg;
   logic [31:0] stall_reg;

   // Saturating counters; flush leaves them untouched, only reset clears them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         retired_reg <= '0;
         stall_reg   <= '0;
      end else begin
         if (out_valid && out_ready && (retired_reg != 32'hFFFF_FFFF))
            retired_reg <= retired_reg + 32'd1;
         if (in_valid && !in_ready && (stall_reg != 32'hFFFF_FFFF))
            stall_reg <= stall_reg + 32'd1;
      end
   end

   assign perf_retired = retired_reg;
   assign perf_stall   = stall_reg;
`endif

endmodule
